// File: rtl/bcd_b.sv
// ---------------------------------------------------------------------------
// bcd_b : sequential 4-digit BCD to 14-bit binary converter.
//
// A reverse double-dabble: the packed BCD operand sits in the top 16 bits of a
// 30-bit work register.  Each CONV cycle shifts the register right by one and
// then pulls 3 off every BCD nibble that reads 8 or more.  After 14 iterations
// the low 14 bits hold the binary value.
//
// Ports
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   conversion request, sampled only while idle
//   q      in   4   thousands digit (BCD)
//   b      in   4   hundreds digit (BCD)
//   s      in   4   tens digit (BCD)
//   g      in   4   units digit (BCD)
//   bin    out 14   binary result, held until the next completion/error
//   busy   out  1   conversion in progress
//   done   out  1   one-cycle pulse when bin/err are valid
//   err    out  1   last accepted request contained a digit above 9
//
// Handshake: start is taken on a rising edge only while busy is low; a request
// taken with all digits legal raises busy for 14 cycles and ends with a
// one-cycle done pulse; a request with an illegal digit gives done+err on the
// very next cycle and never raises busy.  start seen while busy is dropped.
// ---------------------------------------------------------------------------
module bcd_b (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  q,
    input  logic [3:0]  b,
    input  logic [3:0]  s,
    input  logic [3:0]  g,
    output logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state_q;
    logic [29:0] r_q;
    logic [29:0] r_shift;
    logic [29:0] r_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [13:0] bin_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        digit_bad;

    // Undo the "add 3" of the forward algorithm: a BCD nibble that reads 8+
    // after the shift received a carried-in half-ten that must become 5.
    function automatic logic [3:0] fix_nibble(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    always_comb begin
        digit_bad = (q > 4'd9) | (b > 4'd9) | (s > 4'd9) | (g > 4'd9);
        r_shift   = {1'b0, r_q[29:1]};
        r_d       = {fix_nibble(r_shift[29:26]),
                     fix_nibble(r_shift[25:22]),
                     fix_nibble(r_shift[21:18]),
                     fix_nibble(r_shift[17:14]),
                     r_shift[13:0]};
        cnt_d     = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (digit_bad) begin
                            bin_q  <= '0;
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            r_q     <= {q, b, s, g, 14'b0};
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    r_q   <= r_d;
                    cnt_q <= cnt_d;
                    // The 14th iteration's corrected value is captured directly.
                    if (cnt_d == 4'd14) begin
                        bin_q   <= r_d[13:0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bin  = bin_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_b.sv
module tb_bcd_b;

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  q     = 4'd0;
    logic [3:0]  b     = 4'd0;
    logic [3:0]  s     = 4'd0;
    logic [3:0]  g     = 4'd0;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        err;

    bcd_b dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .b     (b),
        .s     (s),
        .g     (g),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; the acceptance edge of a request issued
    // at "#1 after edge k" is edge k+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];   // {err, bin}
    int          acc_q[$];   // acceptance edge index of each request
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: a request's value straight from decimal place weights.
    function automatic logic [14:0] model(input int dq, input int db, input int ds, input int dg);
        if (dq > 9 || db > 9 || ds > 9 || dg > 9) return {1'b1, 14'd0};
        return {1'b0, 14'(1000 * dq + 100 * db + 10 * ds + dg)};
    endfunction

    task automatic push(input int dq, input int db, input int ds, input int dg, input int acc);
        exp_q.push_back(model(dq, db, ds, dg));
        acc_q.push_back(acc);
    endtask

    // ---------------- monitor ----------------
    logic [14:0] m_e;
    int          m_a;
    int          m_busy;

    always @(negedge clk) begin
        if (!rst) begin
            // A legal request keeps busy high from its acceptance edge up to,
            // but not including, the cycle of its done pulse.
            m_busy = 0;
            if (acc_q.size() > 0 && !exp_q[0][14] && cyc >= acc_q[0] && cyc < acc_q[0] + 14)
                m_busy = 1;
            check("busy", int'(busy), m_busy);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got done=1, expected no pending request (cycle %0d)", cyc);
                end else begin
                    m_e = exp_q.pop_front();
                    m_a = acc_q.pop_front();
                    check("bin", int'(bin), int'(m_e[13:0]));
                    check("err", int'(err), int'(m_e[14]));
                    check("done_offset", cyc - m_a, m_e[14] ? 0 : 14);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // One start pulse with the DUT idle, then wait for its response.
    task automatic send(input int dq, input int db, input int ds, input int dg);
        @(posedge clk); #1;
        q = 4'(dq); b = 4'(db); s = 4'(ds); g = 4'(dg);
        start = 1'b1;
        push(dq, db, ds, dg, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        if (!model(dq, db, ds, dg)[14]) begin
            @(negedge clk);
            check("err_clear", int'(err), 0);
        end
        drain();
    endtask

    // start held through every acceptance; digits and start are junk during
    // conversions and must be ignored.
    task automatic run_random(input int n);
        int next_acc;
        int following;
        int dq, db, ds, dg;
        @(posedge clk); #1;
        next_acc = cyc + 1;
        for (int i = 0; i < n; i++) begin
            dq = $urandom_range(0, 9); db = $urandom_range(0, 9);
            ds = $urandom_range(0, 9); dg = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: dq = $urandom_range(10, 15);
                    1: db = $urandom_range(10, 15);
                    2: ds = $urandom_range(10, 15);
                    default: dg = $urandom_range(10, 15);
                endcase
            end
            q = 4'(dq); b = 4'(db); s = 4'(ds); g = 4'(dg);
            start = 1'b1;
            push(dq, db, ds, dg, next_acc);
            following = next_acc + (model(dq, db, ds, dg)[14] ? 1 : 15);
            @(posedge clk); #1;
            while (cyc < following - 1) begin
                start = 1'($urandom_range(0, 1));
                q = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
                s = 4'($urandom_range(0, 15)); g = 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
            next_acc = following;
        end
        start = 1'b0;
        drain();
    endtask

    // ---------------- main sequence ----------------
    int d0;
    int e0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_bin", int'(bin), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;

        // Reset in the middle of converting 1234.
        @(posedge clk); #1;
        q = 4'd1; b = 4'd2; s = 4'd3; g = 4'd4; start = 1'b1;
        push(1, 2, 3, 4, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_bin", int'(bin), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err", int'(err), 0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 0, 0, 0);

        // Maximum operand.
        send(9, 9, 9, 9);

        // Back-to-back: 1234 then 0005 with start held through the done cycle.
        d0 = done_cnt;
        @(posedge clk); #1;
        e0 = cyc + 1;
        q = 4'd1; b = 4'd2; s = 4'd3; g = 4'd4; start = 1'b1;
        push(1, 2, 3, 4, e0);
        push(0, 0, 0, 5, e0 + 15);
        @(posedge clk); #1;
        q = 4'd0; b = 4'd0; s = 4'd0; g = 4'd5;
        repeat (15) @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        check("b2b_done_count", done_cnt - d0, 2);

        // Illegal tens digit, then a legal request that must clear err.
        send(0, 0, 10, 0);
        send(0, 0, 4, 2);

        // 0500 with start pulses and digit changes mid-conversion.
        d0 = done_cnt;
        @(posedge clk); #1;
        q = 4'd0; b = 4'd5; s = 4'd0; g = 4'd0; start = 1'b1;
        push(0, 5, 0, 0, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 14; c++) begin
            if (c == 3 || c == 10) begin
                start = 1'b1; q = 4'd9; s = 4'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; q = 4'd0; s = 4'd0;
        drain();
        repeat (3) @(posedge clk);
        check("ignore_done_count", done_cnt - d0, 1);

        // Randomized sweep with held start and junk inputs while busy.
        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
